regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the datapath register file: 2 asynchronous read ports, 1 synchronous write port, generic width and depth.
- Adds write-to-read bypass and a per-register pending scoreboard for RAW hazard detection.
- Adds a sequential clear-sweep engine for software-initiated register-file zeroing without asserting global reset.
- Sits between decode (issue/read) and writeback in the pipelined CPU.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 4.
- ADDR_W, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- R_addr_A  in  ADDR_W  read address, port A.
- R_addr_B  in  ADDR_W  read address, port B.
- rdata_A  out  DATA_W  read data, port A (combinational).
- rdata_B  out  DATA_W  read data, port B (combinational).
- we  in  1  writeback write enable.
- Wt_addr  in  ADDR_W  writeback address.
- wt_data  in  DATA_W  writeback data.
- iss  in  1  issue strobe; marks iss_addr pending.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- hz_A  out  1  port A source is pending and not satisfied by this cycle's writeback.
- hz_B  out  1  same, for port B.
- clr_req  in  1  start clear sweep (single-cycle pulse or level).
- clr_busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset: synchronous only. On a rising edge with rst=1:
  - all registers 1..NREGS-1 <= 0; all pending bits <= 0.
  - FSM -> IDLE; clr_busy=0, clr_done=0.
  - rst dominates every other input, including mid-sweep.
- Register 0:
  - reads always return 0, never bypassed, never pending.
  - writes, issues and sweep steps targeting 0 are ignored.
- Read path, per port, combinational. Priority:
  - addr==0 -> 0
  - else we && Wt_addr==addr && FSM==IDLE -> wt_data (bypass)
  - else stored value.
- Write: on clock edge when we=1, Wt_addr!=0 and FSM==IDLE, reg[Wt_addr] <= wt_data. Latency 1 cycle to storage; 0 cycles to readers via bypass.
- Scoreboard, FSM==IDLE only:
  - iss=1 sets pending[iss_addr].
  - we=1 clears pending[Wt_addr].
  - Same address in the same cycle: set wins (a newer producer overrides an older writeback).
- Hazard: hz_X = (FSM!=IDLE) || (addr!=0 && pending[addr] && !(we && Wt_addr==addr)).
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr_req=1: ptr <= 1, clr_busy=1.
  - SWEEP: each cycle reg[ptr] <= 0, pending[ptr] <= 0, ptr++.
  - When ptr==NREGS-1 is cleared -> IDLE with clr_done=1 for exactly 1 cycle.
  - Duration: NREGS-1 cycles of clr_busy.
  - During SWEEP, we and iss are ignored (dropped, not queued) and clr_req is ignored.
  - clr_req on the cycle the FSM returns to IDLE starts a new sweep on the next cycle.
- Reads during SWEEP return current storage: already-swept registers read 0, others their old value. Hazards are forced to 1.
- All outputs are registered-state derived except rdata_X and hz_X, which are combinational from inputs.

Decomposition:
- Shared package (cpu_pkg): DATA_W/NREGS defaults, ADDR_W derivation function, FSM state enum (CLR_IDLE, CLR_SWEEP).
- One natural sub-module: regfile_sb_rdport (address compare, bypass mux, hazard term), instantiated twice. Storage, scoreboard and FSM stay in the top.

Test Plan:
- Write/read: we=1, Wt_addr=5, wt_data=0xDEADBEEF; next cycle R_addr_A=5 -> rdata_A=0xDEADBEEF. Write to addr 0 with 0x1234 -> R_addr_B=0 returns 0.
- Bypass: same cycle we=1, Wt_addr=7, wt_data=0xA5A5A5A5, R_addr_A=7 -> rdata_A=0xA5A5A5A5 combinationally; old value not visible.
- Scoreboard: iss=1, iss_addr=3; next cycle R_addr_A=3 -> hz_A=1. Writeback we=1, Wt_addr=3 same cycle -> hz_A=0. Following cycle still 0.
- Set-vs-clear collision: reg 9 pending; iss=1/iss_addr=9 and we=1/Wt_addr=9 same cycle -> next cycle hz for reg 9 = 1, reg9 holds the written data.
- Sweep: load regs 1..31 with index value; pulse clr_req -> clr_busy=1 for 31 cycles, clr_done pulse on cycle 32. All reads return 0 after. A we during the sweep leaves no trace. hz_A=1 throughout.
- Reset mid-sweep: assert rst at sweep cycle 10 -> next edge clr_busy=0, all regs 0, no clr_done pulse. Subsequent write to reg 12 works normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the register file slice: default sizes, the
// address-width helper and the clear-sweep state encoding.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int NREGS_DEF  = 32;

   // Address width needed to index n registers.
   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction

   typedef enum logic {
      CLR_IDLE  = 1'b0,
      CLR_SWEEP = 1'b1
   } clr_state_e;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One asynchronous read port: register-0 masking, writeback bypass and the
// RAW hazard term for the addressed source register.
module regfile_sb_rdport #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              fsm_idle,
   input  logic [DATA_W-1:0] stored_data,
   input  logic              stored_pending,
   output logic [DATA_W-1:0] rdata,
   output logic              hz
);

   logic addr_zero;
   logic wb_hit;

   assign addr_zero = (rd_addr == '0);
   assign wb_hit    = wr_en && (wr_addr == rd_addr);

   // Register 0 reads as zero; a same-cycle writeback is forwarded only while
   // the sweep engine is idle, otherwise the stored value is returned.
   always_comb begin
      rdata = '0;
      if (!addr_zero) begin
         if (fsm_idle && wb_hit) begin
            rdata = wr_data;
         end else begin
            rdata = stored_data;
         end
      end
   end

   // The source is hazardous while the sweep runs, or when its producer is
   // still outstanding and is not the writeback arriving this cycle.
   always_comb begin
      hz = !fsm_idle || (!addr_zero && stored_pending && !wb_hit);
   end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one
// writeback port, a pending-producer scoreboard and a clear-sweep engine.
module regfile_sb
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   localparam int ADDR_W = addr_w(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] R_addr_A,
   input  logic [ADDR_W-1:0] R_addr_B,
   output logic [DATA_W-1:0] rdata_A,
   output logic [DATA_W-1:0] rdata_B,
   input  logic              we,
   input  logic [ADDR_W-1:0] Wt_addr,
   input  logic [DATA_W-1:0] wt_data,
   input  logic              iss,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              hz_A,
   output logic              hz_B,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);
   localparam logic [ADDR_W-1:0] ONE_REG  = ADDR_W'(1);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  pend_q;
   logic [NREGS-1:0]  pend_d;
   clr_state_e        state_q;
   clr_state_e        state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;
   logic              busy_q;
   logic              busy_d;
   logic              done_q;
   logic              done_d;
   logic              fsm_idle;

   assign fsm_idle = (state_q == CLR_IDLE);
   assign clr_busy = busy_q;
   assign clr_done = done_q;

   // Next-state for storage, scoreboard and the sweep engine. While idle the
   // writeback and issue ports update state (issue wins on a collision, since
   // it names a newer producer); while sweeping they are dropped and one
   // register per cycle is zeroed together with its pending bit.
   always_comb begin
      regs_d  = regs_q;
      pend_d  = pend_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         CLR_IDLE: begin
            if (we && (Wt_addr != '0)) begin
               regs_d[Wt_addr] = wt_data;
               pend_d[Wt_addr] = 1'b0;
            end
            if (iss && (iss_addr != '0)) begin
               pend_d[iss_addr] = 1'b1;
            end
            if (clr_req) begin
               state_d = CLR_SWEEP;
               ptr_d   = ONE_REG;
               busy_d  = 1'b1;
            end
         end
         CLR_SWEEP: begin
            regs_d[ptr_q] = '0;
            pend_d[ptr_q] = 1'b0;
            ptr_d         = ptr_q + ONE_REG;
            if (ptr_q == LAST_REG) begin
               state_d = CLR_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = CLR_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
   end

   // All state registers; reset overrides everything, including a sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q  <= '{default: '0};
         pend_q  <= '0;
         state_q <= CLR_IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   regfile_sb_rdport #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_port_a (
      .rd_addr       (R_addr_A),
      .wr_en         (we),
      .wr_addr       (Wt_addr),
      .wr_data       (wt_data),
      .fsm_idle      (fsm_idle),
      .stored_data   (regs_q[R_addr_A]),
      .stored_pending(pend_q[R_addr_A]),
      .rdata         (rdata_A),
      .hz            (hz_A)
   );

   regfile_sb_rdport #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_port_b (
      .rd_addr       (R_addr_B),
      .wr_en         (we),
      .wr_addr       (Wt_addr),
      .wr_data       (wt_data),
      .fsm_idle      (fsm_idle),
      .stored_data   (regs_q[R_addr_B]),
      .stored_pending(pend_q[R_addr_B]),
      .rdata         (rdata_B),
      .hz            (hz_B)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a per-cycle vector table for the read,
// bypass and scoreboard paths, then hand sequences around the clear sweep.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  R_addr_A;
   logic [4:0]  R_addr_B;
   logic [31:0] rdata_A;
   logic [31:0] rdata_B;
   logic        we;
   logic [4:0]  Wt_addr;
   logic [31:0] wt_data;
   logic        iss;
   logic [4:0]  iss_addr;
   logic        hz_A;
   logic        hz_B;
   logic        clr_req;
   logic        clr_busy;
   logic        clr_done;

   int checkCount;
   int passCount;

   typedef struct {
      logic        rst;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iss;
      logic [4:0]  ia;
      logic        clr;
      logic [31:0] expA;
      logic [31:0] expB;
      logic        expHzA;
      logic        expHzB;
      logic        expBusy;
      logic        expDone;
   } vec_t;

   vec_t vecs [21];

   regfile_sb dut (
      .clk     (clk),
      .rst     (rst),
      .R_addr_A(R_addr_A),
      .R_addr_B(R_addr_B),
      .rdata_A (rdata_A),
      .rdata_B (rdata_B),
      .we      (we),
      .Wt_addr (Wt_addr),
      .wt_data (wt_data),
      .iss     (iss),
      .iss_addr(iss_addr),
      .hz_A    (hz_A),
      .hz_B    (hz_B),
      .clr_req (clr_req),
      .clr_busy(clr_busy),
      .clr_done(clr_done)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs at the falling edge and let the
   // combinational outputs settle well before the next rising edge.
   task automatic applyStimulus(input logic r, input logic [4:0] ra, input logic [4:0] rb,
                                input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic is, input logic [4:0] ia, input logic c);
      @(negedge clk);
      rst      = r;
      R_addr_A = ra;
      R_addr_B = rb;
      we       = w;
      Wt_addr  = wa;
      wt_data  = wd;
      iss      = is;
      iss_addr = ia;
      clr_req  = c;
      #2;
   endtask

   task automatic idleCycle(input logic [4:0] ra, input logic [4:0] rb);
      applyStimulus(1'b0, ra, rb, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end else begin
         passCount++;
      end
   endtask

   int busyCount;
   int doneCycle;
   int hzMiss;
   int donePulses;

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst = 1'b1; R_addr_A = '0; R_addr_B = '0; we = 1'b0; Wt_addr = '0;
      wt_data = '0; iss = 1'b0; iss_addr = '0; clr_req = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      idleCycle(5'd5, 5'd31);
      checkOutput("resetBusy", 32'(clr_busy), 32'd0);
      checkOutput("resetDone", 32'(clr_done), 32'd0);
      checkOutput("resetReadA", rdata_A, 32'd0);
      checkOutput("resetHzA", 32'(hz_A), 32'd0);

      //          rst ra    rb    we wa    wd             iss ia  clr expA           expB           hzA hzB bsy dn
      vecs[0]  = '{0, 5'd5, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0};
      vecs[1]  = '{0, 5'd5, 5'd0, 1, 5'd0, 32'h00001234, 0, 5'd0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0};
      vecs[2]  = '{0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'h0,        0, 0, 0, 0};
      vecs[3]  = '{0, 5'd1, 5'd2, 1, 5'd7, 32'h11111111, 0, 5'd0, 0, 32'h0,        32'h0,        0, 0, 0, 0};
      vecs[4]  = '{0, 5'd7, 5'd7, 1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 0};
      vecs[5]  = '{0, 5'd7, 5'd5, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0, 0};
      vecs[6]  = '{0, 5'd3, 5'd0, 0, 5'd0, 32'h0,        1, 5'd3, 0, 32'h0,        32'h0,        0, 0, 0, 0};
      vecs[7]  = '{0, 5'd3, 5'd5, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'hDEADBEEF, 1, 0, 0, 0};
      vecs[8]  = '{0, 5'd3, 5'd0, 1, 5'd3, 32'h00000033, 0, 5'd0, 0, 32'h00000033, 32'h0,        0, 0, 0, 0};
      vecs[9]  = '{0, 5'd3, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h00000033, 32'h0,        0, 0, 0, 0};
      vecs[10] = '{0, 5'd9, 5'd0, 0, 5'd0, 32'h0,        1, 5'd9, 0, 32'h0,        32'h0,        0, 0, 0, 0};
      vecs[11] = '{0, 5'd9, 5'd9, 1, 5'd9, 32'h00000099, 1, 5'd9, 0, 32'h00000099, 32'h00000099, 0, 0, 0, 0};
      vecs[12] = '{0, 5'd9, 5'd9, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h00000099, 32'h00000099, 1, 1, 0, 0};
      vecs[13] = '{0, 5'd9, 5'd0, 1, 5'd9, 32'h0000009A, 0, 5'd0, 0, 32'h0000009A, 32'h0,        0, 0, 0, 0};
      vecs[14] = '{0, 5'd9, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0000009A, 32'h0,        0, 0, 0, 0};
      vecs[15] = '{0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        1, 5'd0, 0, 32'h0,        32'h0,        0, 0, 0, 0};
      vecs[16] = '{0, 5'd10, 5'd0, 0, 5'd0, 32'h0,       1, 5'd10, 0, 32'h0,       32'h0,        0, 0, 0, 0};
      vecs[17] = '{1, 5'd10, 5'd4, 1, 5'd4, 32'h00000044, 1, 5'd4, 0, 32'h0,       32'h00000044, 1, 0, 0, 0};
      vecs[18] = '{0, 5'd10, 5'd4, 0, 5'd0, 32'h0,       0, 5'd0, 0, 32'h0,        32'h0,        0, 0, 0, 0};
      vecs[19] = '{0, 5'd5, 5'd9, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'h0,        0, 0, 0, 0};
      vecs[20] = '{0, 5'd7, 5'd3, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'h0,        0, 0, 0, 0};

      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].we, vecs[i].wa,
                       vecs[i].wd, vecs[i].iss, vecs[i].ia, vecs[i].clr);
         checkOutput($sformatf("vec%0d.rdataA", i), rdata_A, vecs[i].expA);
         checkOutput($sformatf("vec%0d.rdataB", i), rdata_B, vecs[i].expB);
         checkOutput($sformatf("vec%0d.hzA", i), 32'(hz_A), 32'(vecs[i].expHzA));
         checkOutput($sformatf("vec%0d.hzB", i), 32'(hz_B), 32'(vecs[i].expHzB));
         checkOutput($sformatf("vec%0d.busy", i), 32'(clr_busy), 32'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d.done", i), 32'(clr_done), 32'(vecs[i].expDone));
      end

      // Full sweep with every register holding its own index
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0);
      end
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
      checkOutput("sweepStartBusy", 32'(clr_busy), 32'd0);
      busyCount = 0; doneCycle = 0; hzMiss = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 3) begin
            idleCycle(5'd2, 5'd30);
            checkOutput("sweepSweptReg", rdata_A, 32'd0);
            checkOutput("sweepUnsweptReg", rdata_B, 32'd30);
         end else if (c == 5) begin
            applyStimulus(1'b0, 5'd1, 5'd0, 1'b1, 5'd3, 32'h0000FFFF, 1'b1, 5'd4, 1'b1);
         end else if (c == 32) begin
            applyStimulus(1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
         end else begin
            idleCycle(5'd1, 5'd0);
         end
         if (clr_done) begin
            doneCycle = c;
            break;
         end
         if (clr_busy) begin
            busyCount++;
            if (!hz_A) hzMiss++;
         end
      end
      checkOutput("sweepBusyCycles", 32'(busyCount), 32'd31);
      checkOutput("sweepDoneCycle", 32'(doneCycle), 32'd32);
      checkOutput("sweepHzForced", 32'(hzMiss), 32'd0);
      checkOutput("sweepDoneBusyLow", 32'(clr_busy), 32'd0);
      checkOutput("sweepDroppedWrite", rdata_A, 32'd0);
      checkOutput("sweepDroppedIssHzA", 32'(hz_A), 32'd0);
      checkOutput("sweepDroppedIssHzB", 32'(hz_B), 32'd0);

      // Request raised in the done cycle starts the next sweep immediately
      idleCycle(5'd20, 5'd21);
      checkOutput("backToBackBusy", 32'(clr_busy), 32'd1);
      checkOutput("backToBackDone", 32'(clr_done), 32'd0);
      doneCycle = 0;
      for (int c = 2; c <= 40; c++) begin
         idleCycle(5'd0, 5'd0);
         if (clr_done) begin
            doneCycle = c;
            break;
         end
      end
      checkOutput("sweep2DoneCycle", 32'(doneCycle), 32'd32);

      // Reset in the middle of a sweep
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i + 256), 1'b0, 5'd0, 1'b0);
      end
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
      for (int c = 1; c < 10; c++) idleCycle(5'd20, 5'd0);
      checkOutput("preResetUnswept", rdata_A, 32'h00000114);
      applyStimulus(1'b1, 5'd20, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
      checkOutput("midSweepBusy", 32'(clr_busy), 32'd1);
      idleCycle(5'd20, 5'd31);
      checkOutput("postResetBusy", 32'(clr_busy), 32'd0);
      checkOutput("postResetDone", 32'(clr_done), 32'd0);
      checkOutput("postResetReg20", rdata_A, 32'd0);
      checkOutput("postResetReg31", rdata_B, 32'd0);
      checkOutput("postResetHzA", 32'(hz_A), 32'd0);
      donePulses = 0;
      for (int c = 0; c < 35; c++) begin
         idleCycle(5'd0, 5'd0);
         if (clr_done || clr_busy) donePulses++;
      end
      checkOutput("postResetNoSweep", 32'(donePulses), 32'd0);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd12, 32'h00C0FFEE, 1'b0, 5'd0, 1'b0);
      idleCycle(5'd12, 5'd11);
      checkOutput("postResetWriteA", rdata_A, 32'h00C0FFEE);
      checkOutput("postResetWriteB", rdata_B, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
